// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serial run detector:
//   - state encodings of the detector FSM (IDLE / COUNT / HIT)
//   - run_len_width(): width needed to hold a saturating count 0..max_val
// -----------------------------------------------------------------------------
package seq_pkg;

  // Raw state encodings. 2'b11 is unused and treated as corrupted state.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_HIT   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,   // run_len == 0
    COUNT = ST_COUNT,  // 0 < run_len < RUN_LEN
    HIT   = ST_HIT     // run_len == RUN_LEN
  } state_e;

  // Bits required to represent every value of a counter that saturates at
  // max_val. Never returns less than 1 so a port is always at least one bit.
  function automatic int run_len_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage : seq_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high reset (q -> 0)
//   inc    in   add one on this edge, holding at 2^W-1
//   clr    in   synchronous clear; clr together with inc loads 1 so that an
//               event coinciding with the clear is not lost
//   q      out  W-bit count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = inc ? W'(1) : '0;
    end else if (inc && !(&q_q)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : sat_counter

// File: rtl/seq_run_detector.sv
// -----------------------------------------------------------------------------
// seq_run_detector
// Detects a run of RUN_LEN consecutive enabled samples of w equal to
// match_val. Detection is level based: a run longer than RUN_LEN keeps z high
// and produces only one z_pulse / one det_count increment.
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   en         in   sample enable; w is ignored when en=0 (state holds)
//   w          in   serial data bit
//   match_val  in   bit value being searched for
//   clr_cnt    in   synchronous clear of det_count
//   z          out  high while in HIT (decoded from the state register only)
//   z_pulse    out  registered one-cycle pulse on each entry into HIT
//   run_len    out  consecutive-match count, saturating at RUN_LEN
//   det_count  out  saturating number of HIT entries since reset / clear
// -----------------------------------------------------------------------------
module seq_run_detector
  import seq_pkg::*;
#(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 en,
  input  logic                                 w,
  input  logic                                 match_val,
  input  logic                                 clr_cnt,
  output logic                                 z,
  output logic                                 z_pulse,
  output logic [run_len_width(RUN_LEN)-1:0]    run_len,
  output logic [CNT_W-1:0]                     det_count
);

  localparam int                RL_W   = run_len_width(RUN_LEN);
  localparam logic [RL_W-1:0]   RL_MAX = RL_W'(RUN_LEN);

  state_e            state_q;
  state_e            state_d;
  logic [RL_W-1:0]   run_len_q;
  logic [RL_W-1:0]   run_len_d;
  logic              z_pulse_q;
  logic              z_pulse_d;
  logic              sample_match;
  logic              hit_entry;

  assign sample_match = (w == match_val);

  // Next-state logic. Defaults hold the current state so en=0 needs no
  // explicit branch.
  // NOTE: every signal driven here gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    run_len_d = run_len_q;

    case (state_q)
      IDLE: begin
        run_len_d = '0;
        if (en && sample_match) begin
          if (RUN_LEN == 1) begin
            state_d   = HIT;
            run_len_d = RL_MAX;
          end else begin
            state_d   = COUNT;
            run_len_d = RL_W'(1);
          end
        end
      end

      COUNT: begin
        if (en) begin
          if (sample_match) begin
            run_len_d = run_len_q + RL_W'(1);
            // >= rather than == so a corrupted run_len cannot overshoot.
            if (run_len_q + RL_W'(1) >= RL_MAX) begin
              state_d   = HIT;
              run_len_d = RL_MAX;
            end
          end else begin
            state_d   = IDLE;
            run_len_d = '0;
          end
        end
      end

      HIT: begin
        run_len_d = RL_MAX;
        if (en && !sample_match) begin
          state_d   = IDLE;
          run_len_d = '0;
        end
      end

      // Unused encoding: recover unconditionally, even with en=0.
      default: begin
        state_d   = IDLE;
        run_len_d = '0;
      end
    endcase
  end

  // Entry into HIT is the only event that pulses or counts; a run that stays
  // in HIT never re-enters it.
  assign hit_entry = (state_d == HIT) && (state_q != HIT);
  assign z_pulse_d = hit_entry;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      run_len_q <= '0;
      z_pulse_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_len_q <= run_len_d;
      z_pulse_q <= z_pulse_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_det_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_entry),
    .clr   (clr_cnt),
    .q     (det_count)
  );

  // Moore output: decoded from the state register only.
  assign z       = (state_q == HIT);
  assign z_pulse = z_pulse_q;
  assign run_len = run_len_q;

endmodule : seq_run_detector

// File: tb/tb_seq_run_detector.sv
// -----------------------------------------------------------------------------
// tb_seq_run_detector
// Four detector instances (RUN_LEN 1..4, mixed counter widths) share one
// input stream. A model tracks the unsaturated streak of matching enabled
// samples per instance and derives every output from it; a compare process
// checks all instances each falling edge. Directed sequences pin literal
// expectations before a long randomized run.
// -----------------------------------------------------------------------------
module tb_seq_run_detector;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic w;
  logic match_val;
  logic clr_cnt;

  always #5 clk = ~clk;

  // Instance 0: RUN_LEN=1 CNT_W=4; 1: RUN_LEN=2 CNT_W=2;
  // 2: RUN_LEN=3 CNT_W=8;         3: RUN_LEN=4 CNT_W=8
  int n_of    [NI] = '{1, 2, 3, 4};
  int cnt_max [NI] = '{15, 3, 255, 255};

  logic       z1, z2, z3, z4;
  logic       p1, p2, p3, p4;
  logic [0:0] rl1;
  logic [1:0] rl2;
  logic [1:0] rl3;
  logic [2:0] rl4;
  logic [3:0] dc1;
  logic [1:0] dc2;
  logic [7:0] dc3;
  logic [7:0] dc4;

  seq_run_detector #(.RUN_LEN(1), .CNT_W(4)) u_n1 (
    .clk(clk), .reset(reset), .en(en), .w(w), .match_val(match_val),
    .clr_cnt(clr_cnt), .z(z1), .z_pulse(p1), .run_len(rl1), .det_count(dc1));
  seq_run_detector #(.RUN_LEN(2), .CNT_W(2)) u_n2 (
    .clk(clk), .reset(reset), .en(en), .w(w), .match_val(match_val),
    .clr_cnt(clr_cnt), .z(z2), .z_pulse(p2), .run_len(rl2), .det_count(dc2));
  seq_run_detector #(.RUN_LEN(3), .CNT_W(8)) u_n3 (
    .clk(clk), .reset(reset), .en(en), .w(w), .match_val(match_val),
    .clr_cnt(clr_cnt), .z(z3), .z_pulse(p3), .run_len(rl3), .det_count(dc3));
  seq_run_detector #(.RUN_LEN(4), .CNT_W(8)) u_n4 (
    .clk(clk), .reset(reset), .en(en), .w(w), .match_val(match_val),
    .clr_cnt(clr_cnt), .z(z4), .z_pulse(p4), .run_len(rl4), .det_count(dc4));

  int z_v  [NI];
  int p_v  [NI];
  int rl_v [NI];
  int dc_v [NI];

  always_comb begin
    z_v[0]  = int'(z1);  z_v[1]  = int'(z2);  z_v[2]  = int'(z3);  z_v[3]  = int'(z4);
    p_v[0]  = int'(p1);  p_v[1]  = int'(p2);  p_v[2]  = int'(p3);  p_v[3]  = int'(p4);
    rl_v[0] = int'(rl1); rl_v[1] = int'(rl2); rl_v[2] = int'(rl3); rl_v[3] = int'(rl4);
    dc_v[0] = int'(dc1); dc_v[1] = int'(dc2); dc_v[2] = int'(dc3); dc_v[3] = int'(dc4);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: streak = number of consecutive matching enabled samples
  // (unsaturated). Detection occurs on the sample that makes streak equal N.
  // ---------------------------------------------------------------------------
  int m_streak [NI] = '{0, 0, 0, 0};
  int m_dc     [NI] = '{0, 0, 0, 0};
  int m_pulse  [NI] = '{0, 0, 0, 0};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NI; i++) begin
        m_streak[i] = 0;
        m_dc[i]     = 0;
        m_pulse[i]  = 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        int hit;
        hit = 0;
        if (en === 1'b1) begin
          if (w === match_val) begin
            if (m_streak[i] < 1000) m_streak[i]++;
            hit = (m_streak[i] == n_of[i]) ? 1 : 0;
          end else begin
            m_streak[i] = 0;
          end
        end
        m_pulse[i] = hit;
        if (clr_cnt === 1'b1)                   m_dc[i] = hit;
        else if (hit == 1 && m_dc[i] < cnt_max[i]) m_dc[i]++;
      end
    end
  end

  bit cmp_on = 1'b0;

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < NI; i++) begin
        int exp_rl;
        exp_rl = (m_streak[i] < n_of[i]) ? m_streak[i] : n_of[i];
        check($sformatf("model z N=%0d", n_of[i]), z_v[i],
              (m_streak[i] >= n_of[i]) ? 1 : 0);
        check($sformatf("model z_pulse N=%0d", n_of[i]), p_v[i], m_pulse[i]);
        check($sformatf("model run_len N=%0d", n_of[i]), rl_v[i], exp_rl);
        check($sformatf("model det_count N=%0d", n_of[i]), dc_v[i], m_dc[i]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 2 time units after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step(input logic e, input logic wv, input logic c);
    en      = e;
    w       = wv;
    clr_cnt = c;
    @(posedge clk);
    #2;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset z N=%0d", n_of[i]), z_v[i], 0);
      check($sformatf("reset z_pulse N=%0d", n_of[i]), p_v[i], 0);
      check($sformatf("reset run_len N=%0d", n_of[i]), rl_v[i], 0);
      check($sformatf("reset det_count N=%0d", n_of[i]), dc_v[i], 0);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  int seq_w  [6];
  int seq_z  [6];
  int seq_rl [6];
  int seq_dc [5];
  int pulses;

  initial begin
    reset     = 1'b1;
    en        = 1'b0;
    w         = 1'b0;
    match_val = 1'b1;
    clr_cnt   = 1'b0;
    @(posedge clk);
    #2;
    do_reset();
    cmp_on = 1'b1;

    // RUN_LEN=2, w=0,1,1,1,0 -> z 0,0,1,1,0 after each sample
    check("r2 z before samples", z_v[1], 0);
    seq_w = '{0, 1, 1, 1, 0, 0};
    seq_z = '{0, 0, 1, 1, 0, 0};
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, seq_w[k][0], 1'b0);
      check($sformatf("r2 z sample %0d", k), z_v[1], seq_z[k]);
      pulses += p_v[1];
    end
    check("r2 pulse count", pulses, 1);
    check("r2 det_count", dc_v[1], 1);

    // RUN_LEN=3, w=1,1,0,1,1,1
    do_reset();
    seq_w  = '{1, 1, 0, 1, 1, 1};
    seq_rl = '{1, 2, 0, 1, 2, 3};
    seq_z  = '{0, 0, 0, 0, 0, 1};
    for (int k = 0; k < 6; k++) begin
      step(1'b1, seq_w[k][0], 1'b0);
      check($sformatf("r3 run_len sample %0d", k), rl_v[2], seq_rl[k]);
      check($sformatf("r3 z sample %0d", k), z_v[2], seq_z[k]);
    end

    // RUN_LEN=2, en toggling 1,0,1 with w=1
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    check("en1 z", z_v[1], 0);
    check("en1 run_len", rl_v[1], 1);
    step(1'b0, 1'b1, 1'b0);
    check("en0 z", z_v[1], 0);
    check("en0 run_len held", rl_v[1], 1);
    check("en0 z_pulse", p_v[1], 0);
    step(1'b1, 1'b1, 1'b0);
    check("en1b z", z_v[1], 1);
    check("en1b z_pulse", p_v[1], 1);

    // CNT_W=2 saturation, then clear coincident with a hit, then plain clear
    do_reset();
    seq_dc = '{1, 2, 3, 3, 3};
    for (int r = 0; r < 5; r++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check($sformatf("sat det_count run %0d", r), dc_v[1], seq_dc[r]);
      step(1'b1, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("clr with hit det_count", dc_v[1], 1);
    step(1'b1, 1'b0, 1'b1);
    check("clr alone det_count", dc_v[1], 0);

    // RUN_LEN=4, reset after 3 matches discards the partial run
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0);
    check("r4 partial run_len", rl_v[3], 3);
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0);
    check("r4 after reset 3 matches z", z_v[3], 0);
    step(1'b1, 1'b1, 1'b0);
    check("r4 after reset 4 matches z", z_v[3], 1);

    // RUN_LEN=1, match_val=0, w=1,0,0,1 -> z 0,1,1,0
    do_reset();
    match_val = 1'b0;
    seq_w = '{1, 0, 0, 1, 0, 0};
    seq_z = '{0, 1, 1, 0, 0, 0};
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, seq_w[k][0], 1'b0);
      check($sformatf("r1 z sample %0d", k), z_v[0], seq_z[k]);
      pulses += p_v[0];
    end
    check("r1 pulse count", pulses, 1);
    check("r1 det_count", dc_v[0], 1);

    // Randomized phase: the compare process checks every cycle.
    match_val = 1'b1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic e;
      logic wv;
      logic cl;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 19) == 0) match_val = ~match_val;
        e  = ($urandom_range(0, 3) != 0);
        wv = ($urandom_range(0, 9) < 7) ? match_val : ~match_val;
        cl = ($urandom_range(0, 29) == 0);
        step(e, wv, cl);
      end
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seq_run_detector

// File: doc/seq_run_detector.md
SEQ_RUN_DETECTOR -- requirements
Module: seq_run_detector

Interface
REQ-001 Parameter RUN_LEN, default 2, number of consecutive matching samples required for detection; legal range 1..255.
REQ-002 Parameter CNT_W, default 8, width of the detection event counter; legal range 1..32.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  sample enable; w is evaluated only on cycles with en=1.
REQ-006 w  input  1  serial data bit under test.
REQ-007 match_val  input  1  bit value being detected; a sample matches when w==match_val.
REQ-008 clr_cnt  input  1  synchronous clear of det_count.
REQ-009 z  output  1  Moore level output, high while the run length has reached RUN_LEN.
REQ-010 z_pulse  output  1  one-cycle registered pulse on each entry into detection.
REQ-011 run_len  output  $clog2(RUN_LEN+1)  current consecutive-match count, saturating at RUN_LEN.
REQ-012 det_count  output  CNT_W  number of detections since reset or clear, saturating.

Function
REQ-013 FSM states: IDLE (run_len=0), COUNT (0<run_len<RUN_LEN), HIT (run_len=RUN_LEN).
REQ-014 en=1, match: IDLE->COUNT (->HIT directly if RUN_LEN=1); COUNT increments run_len, entering HIT when run_len reaches RUN_LEN; HIT stays HIT.
REQ-015 en=1, mismatch: any state -> IDLE, run_len=0, on the next edge.
REQ-016 en=0: state, run_len and z hold their values; z_pulse is 0.
REQ-017 z is a function of registered state only (z=1 iff state==HIT); there is no combinational path from w, en or match_val to z.
REQ-018 Latency: with RUN_LEN=N, z rises in the cycle following the edge that samples the N-th consecutive match, and falls in the cycle following the edge that samples a mismatch.
REQ-019 Detection is level/overlapping: a continuous run of matches produces one z high interval and one z_pulse, regardless of length.
REQ-020 z_pulse is high for exactly the first cycle of each HIT interval.
REQ-021 det_count increments by 1 on each transition into HIT; it holds at 2^CNT_W-1 on overflow (no wrap-around).
REQ-022 If clr_cnt=1 in the same cycle as a transition into HIT, det_count becomes 1; otherwise clr_cnt sets det_count to 0.
REQ-023 A change of match_val mid-run is handled as an ordinary sample: the next sample is compared against the new value, with no extra reset of the run.
REQ-024 Illegal state encodings recover to IDLE on the next edge.

Reset
REQ-025 reset=1 asynchronously forces state=IDLE, run_len=0, z=0, z_pulse=0 and det_count=0.
REQ-026 Reset asserted mid-run discards the partial run; after release, detection requires a full RUN_LEN fresh matches.

Structure
REQ-027 The state encoding localparams (IDLE, COUNT, HIT) and the saturating-increment width helper belong in the shared package seq_pkg.
REQ-028 The saturating event counter is a sub-module named sat_counter (parameter W; ports clk, reset, inc, clr, q).
REQ-029 Next-state/output logic uses one clocked state process and one combinational next-state process with a default next-state assignment.

Verification
REQ-030 RUN_LEN=2, match_val=1, en=1, w=0,1,1,1,0 -> z=0,0,0,1,1,0 (one cycle after each sample), z_pulse high once, det_count=1.
REQ-031 RUN_LEN=3, w=1,1,0,1,1,1 -> z stays 0 until after the sixth sample; run_len goes 1,2,0,1,2,3.
REQ-032 RUN_LEN=2, w=1, en toggling 1,0,1 -> z rises only after the second enabled sample; state holds during the en=0 cycle.
REQ-033 CNT_W=2, five separate runs of 2 matches -> det_count goes 1,2,3,3,3; clr_cnt coincident with the next hit -> det_count=1.
REQ-034 RUN_LEN=4, reset pulsed after 3 matches -> all outputs 0 immediately; 4 further matches are required before z=1.
REQ-035 RUN_LEN=1, match_val=0, w=1,0,0,1 -> z=0,1,1,0 (one cycle after each sample), z_pulse once, det_count=1.
